// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner: synchronizes and debounces the loop sensor, then latches arrivals as a pending car_present request until Prospect green.
module car_sensor_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W = $clog2(DB_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_raw,
    input  logic [2:0] light_pros,
    output logic       car_present,
    output logic       car_arrive,
    output logic       sensor_db,
    output logic [3:0] wait_cnt
);
    typedef enum logic [1:0] {IDLE, RISE, HIGH, FALL} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
    state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic s1, s2, req, commit, drop, serve, sensor_db_next, req_next;
    logic [3:0] wait_next;
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            sensor_db   <= 1'b0;
            car_arrive  <= 1'b0;
            req         <= 1'b0;
            car_present <= 1'b0;
            wait_cnt    <= 4'd0;
        end else begin
            s1          <= sensor_raw;
            s2          <= s1;
            state       <= state_next;
            cnt         <= cnt_next;
            sensor_db   <= sensor_db_next;
            car_arrive  <= commit;
            req         <= req_next;
            car_present <= req_next | sensor_db_next;
            wait_cnt    <= wait_next;
        end
    end
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                state_next = s2 ? RISE : IDLE;
                cnt_next   = s2 ? CNT_W'(1) : '0;
            end
            RISE: begin
                if (!s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == LAST) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end else cnt_next = cnt + CNT_W'(1);
            end
            HIGH: begin
                state_next = s2 ? HIGH : FALL;
                cnt_next   = s2 ? cnt : CNT_W'(1);
            end
            FALL: begin
                if (s2) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    drop       = 1'b1;
                end else cnt_next = cnt + CNT_W'(1);
            end
        endcase
    end
    // set wins over serve for both the request latch and the arrival count
    always_comb begin
        serve          = light_pros == 3'b100;
        sensor_db_next = commit | (sensor_db & ~drop);
        req_next       = commit | (req & ~serve);
        wait_next      = serve ? {3'b000, commit} :
                         commit ? ((wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1) : wait_cnt;
    end
endmodule

// File: tb/tb_car_sensor_conditioner.sv
// tb_car_sensor_conditioner: directed checks of debounce latency, glitch rejection, request latching and saturation.
module tb_car_sensor_conditioner;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor_raw = 1'b0;
    logic [2:0] light_pros = 3'b001;
    logic       car_present, car_arrive, sensor_db;
    logic [3:0] wait_cnt;
    int compared = 0;
    int mismatched = 0;
    int arr_cnt = 0;
    int arr0;

    car_sensor_conditioner dut (
        .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .light_pros(light_pros),
        .car_present(car_present), .car_arrive(car_arrive),
        .sensor_db(sensor_db), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (car_arrive === 1'b1) arr_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        sensor_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_cp", car_present, 0);
            chk("rst_db", sensor_db, 0);
            chk("rst_arr", car_arrive, 0);
            chk("rst_wait", wait_cnt, 0);
        end
        rst = 1'b1;
        step(5);
        chk("lat5_cp", car_present, 0);
        step(1);
        chk("lat6_cp", car_present, 1);
        chk("lat6_db", sensor_db, 1);
        chk("lat6_arr", car_arrive, 1);
        chk("lat6_wait", wait_cnt, 1);
        step(1);
        chk("strobe_one", car_arrive, 0);
        sensor_raw = 1'b0;
        light_pros = 3'b100;
        step(1);
        light_pros = 3'b001;
        chk("srv_wait", wait_cnt, 0);
        chk("srv_cp_held", car_present, 1);
        step(10);
        chk("idle_db", sensor_db, 0);
        chk("idle_cp", car_present, 0);

        arr0 = arr_cnt;
        sensor_raw = 1'b1;
        step(3);
        sensor_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("g3_cp", car_present, 0);
            chk("g3_db", sensor_db, 0);
        end
        chk("g3_wait", wait_cnt, 0);
        chk("g3_arr", arr_cnt - arr0, 0);

        sensor_raw = 1'b1;
        step(5);
        sensor_raw = 1'b0;
        step(12);
        chk("g5_arr", arr_cnt - arr0, 1);
        chk("g5_wait", wait_cnt, 1);
        chk("g5_cp", car_present, 1);
        chk("g5_db", sensor_db, 0);

        sensor_raw = 1'b1;
        step(8);
        chk("ed_db_hi", sensor_db, 1);
        sensor_raw = 1'b0;
        step(20);
        chk("ed_db_lo", sensor_db, 0);
        chk("ed_cp", car_present, 1);
        chk("ed_wait", wait_cnt, 2);
        light_pros = 3'b111;
        step(1);
        chk("multihot_cp", car_present, 1);
        chk("multihot_wait", wait_cnt, 2);
        light_pros = 3'b100;
        step(1);
        light_pros = 3'b001;
        chk("ed_srv_cp", car_present, 0);
        chk("ed_srv_wait", wait_cnt, 0);
        step(2);

        sensor_raw = 1'b1;
        step(5);
        light_pros = 3'b100;
        step(1);
        light_pros = 3'b001;
        chk("coll_cp", car_present, 1);
        chk("coll_wait", wait_cnt, 1);
        chk("coll_arr", car_arrive, 1);
        step(1);
        chk("coll_arr_off", car_arrive, 0);
        sensor_raw = 1'b0;
        light_pros = 3'b100;
        step(1);
        light_pros = 3'b001;
        step(10);
        chk("coll_clr_cp", car_present, 0);
        chk("coll_clr_wait", wait_cnt, 0);

        arr0 = arr_cnt;
        for (int i = 0; i < 17; i++) begin
            sensor_raw = 1'b1;
            step(7);
            chk("sat_wait", wait_cnt, (i + 1 > 15) ? 15 : i + 1);
            sensor_raw = 1'b0;
            step(7);
        end
        chk("sat_arr", arr_cnt - arr0, 17);
        chk("sat_final", wait_cnt, 15);
        light_pros = 3'b100;
        step(1);
        light_pros = 3'b001;
        step(2);
        chk("sat_srv", wait_cnt, 0);

        sensor_raw = 1'b1;
        step(4);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk("mid_rst_cp", car_present, 0);
        step(5);
        chk("mid5_cp", car_present, 0);
        chk("mid5_db", sensor_db, 0);
        step(1);
        chk("mid6_cp", car_present, 1);
        chk("mid6_arr", car_arrive, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
